// File: rtl/code_map_reg_pkg.sv
// Shared types and helpers for the code_map_reg mapper: output-stage FSM states
// and the table depth derived from the code width.
package code_map_reg_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic int unsigned table_depth(input int unsigned code_w);
        return 32'd1 << code_w;
    endfunction

endpackage

// File: rtl/code_map_reg_if.sv
// Valid/ready handshake bundle between the code source, the mapper and the
// consumer of mapped results.
interface code_map_reg_if #(
    parameter int CODE_W = 2,
    parameter int OUT_W  = 1
);
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_hit;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_hit
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_hit
    );
endinterface

// File: rtl/code_map_reg_table.sv
// Programmable mapping table: one {data, en} entry per code, synchronous write,
// combinational read so a same-cycle lookup sees the pre-write contents.
module code_map_table
    import code_map_reg_pkg::*;
#(
    parameter int               CODE_W      = 2,
    parameter int               OUT_W       = 1,
    parameter logic [OUT_W-1:0] DEFAULT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [CODE_W-1:0] wr_addr,
    input  logic [OUT_W-1:0]  wr_data,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] rd_addr,
    output logic [OUT_W-1:0]  rd_data,
    output logic              rd_en
);
    localparam int DEPTH = int'(table_depth(CODE_W));

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             en;
    } entry_t;

    entry_t mem_r [DEPTH];

    // Entry storage; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{data: DEFAULT_VAL, en: 1'b0};
            end
        end else if (we) begin
            mem_r[wr_addr] <= '{data: wr_data, en: wr_en};
        end
    end

    assign rd_data = mem_r[rd_addr].data;
    assign rd_en   = mem_r[rd_addr].en;

endmodule

// File: rtl/code_map_reg.sv
// Registered code-to-value mapper: table lookup on accept, one-entry output
// stage with valid/ready, and a saturating miss counter with sticky flag.
module code_map_reg
    import code_map_reg_pkg::*;
#(
    parameter int               CODE_W      = 2,
    parameter int               OUT_W       = 1,
    parameter int               CNT_W       = 8,
    parameter logic [OUT_W-1:0] DEFAULT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CODE_W-1:0] cfg_addr,
    input  logic [OUT_W-1:0]  cfg_data,
    input  logic              cfg_en,
    code_map_reg_if.slave     bus,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic              miss_sticky,
    input  logic              miss_clr
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_r, state_s;
    logic [OUT_W-1:0]   out_data_r, lookup_data_s, rd_data_s;
    logic               out_hit_r, lookup_hit_s, rd_en_s;
    logic [CNT_W-1:0]   miss_cnt_r, cnt_base_s, cnt_s;
    logic               miss_sticky_r, sticky_base_s, sticky_s;
    logic               in_ready_s, accept_s, miss_s;

    code_map_table #(
        .CODE_W      (CODE_W),
        .OUT_W       (OUT_W),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_we),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .wr_en   (cfg_en),
        .rd_addr (bus.in_code),
        .rd_data (rd_data_s),
        .rd_en   (rd_en_s)
    );

    // Handshake, next state, lookup result and miss bookkeeping.
    always_comb begin
        in_ready_s = (state_r == EMPTY) || bus.out_ready;
        accept_s   = bus.in_valid && in_ready_s;
        state_s    = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) state_s = FULL;
                else          state_s = EMPTY;
            end
            FULL: begin
                if (bus.out_ready && !accept_s) state_s = EMPTY;
                else                            state_s = FULL;
            end
            default: state_s = EMPTY;
        endcase

        if (rd_en_s) begin
            lookup_data_s = rd_data_s;
            lookup_hit_s  = 1'b1;
        end else begin
            lookup_data_s = DEFAULT_VAL;
            lookup_hit_s  = 1'b0;
        end

        miss_s = accept_s && !rd_en_s;

        // A clear lands before a same-cycle miss is counted.
        if (miss_clr) begin
            cnt_base_s    = '0;
            sticky_base_s = 1'b0;
        end else begin
            cnt_base_s    = miss_cnt_r;
            sticky_base_s = miss_sticky_r;
        end

        if (miss_s && (cnt_base_s != CNT_MAX)) cnt_s = cnt_base_s + CNT_W'(1);
        else                                   cnt_s = cnt_base_s;
        sticky_s = sticky_base_s | miss_s;
    end

    // State, output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= EMPTY;
            out_data_r    <= DEFAULT_VAL;
            out_hit_r     <= 1'b0;
            miss_cnt_r    <= '0;
            miss_sticky_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            miss_cnt_r    <= cnt_s;
            miss_sticky_r <= sticky_s;
            if (accept_s) begin
                out_data_r <= lookup_data_s;
                out_hit_r  <= lookup_hit_s;
            end else begin
                out_data_r <= out_data_r;
                out_hit_r  <= out_hit_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == FULL);
    assign bus.out_data  = out_data_r;
    assign bus.out_hit   = out_hit_r;
    assign miss_cnt      = miss_cnt_r;
    assign miss_sticky   = miss_sticky_r;

endmodule

// File: tb/tb_code_map_reg.sv
// Directed, table-driven bench for code_map_reg: a default-width instance for
// mapping/handshake/reset checks and a CNT_W=2 instance for saturation.
module tb_code_map_reg;
    import code_map_reg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    code_map_reg_if #(.CODE_W(2), .OUT_W(1)) bus1 ();
    code_map_reg_if #(.CODE_W(2), .OUT_W(1)) bus2 ();

    logic       cfg_we1, cfg_en1, miss_clr1, miss_sticky1;
    logic [1:0] cfg_addr1;
    logic       cfg_data1;
    logic [7:0] miss_cnt1;

    logic       cfg_we2, cfg_en2, miss_clr2, miss_sticky2;
    logic [1:0] cfg_addr2;
    logic       cfg_data2;
    logic [1:0] miss_cnt2;

    code_map_reg #(.CODE_W(2), .OUT_W(1), .CNT_W(8), .DEFAULT_VAL(1'b0)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we1), .cfg_addr(cfg_addr1),
        .cfg_data(cfg_data1), .cfg_en(cfg_en1), .bus(bus1),
        .miss_cnt(miss_cnt1), .miss_sticky(miss_sticky1), .miss_clr(miss_clr1)
    );

    code_map_reg #(.CODE_W(2), .OUT_W(1), .CNT_W(2), .DEFAULT_VAL(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2),
        .cfg_data(cfg_data2), .cfg_en(cfg_en2), .bus(bus2),
        .miss_cnt(miss_cnt2), .miss_sticky(miss_sticky2), .miss_clr(miss_clr2)
    );

    typedef struct {
        logic [1:0] code;
        logic       exp_data;
        logic       exp_hit;
    } vec_t;

    vec_t vecs [13];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back accepted codes with out_ready=1; checks result and running miss count.
    task automatic run_vecs(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_code  = vecs[i].code;
            step();
            chk({tag, "_valid"}, 32'(bus1.out_valid), 32'd1);
            chk({tag, "_data"},  32'(bus1.out_data),  32'(vecs[i].exp_data));
            chk({tag, "_hit"},   32'(bus1.out_hit),   32'(vecs[i].exp_hit));
            if (!vecs[i].exp_hit) exp_cnt++;
            chk({tag, "_cnt"},   32'(miss_cnt1),      32'(exp_cnt));
        end
    endtask

    initial begin
        // all-miss sweep with empty table
        vecs[0]  = '{2'd0, 1'b0, 1'b0};
        vecs[1]  = '{2'd1, 1'b0, 1'b0};
        vecs[2]  = '{2'd2, 1'b0, 1'b0};
        vecs[3]  = '{2'd3, 1'b0, 1'b0};
        // programmed table: 0=0,1=1,2=0 enabled, 3 disabled
        vecs[4]  = '{2'd1, 1'b1, 1'b1};
        vecs[5]  = '{2'd3, 1'b0, 1'b0};
        vecs[6]  = '{2'd0, 1'b0, 1'b1};
        vecs[7]  = '{2'd1, 1'b1, 1'b1};
        vecs[8]  = '{2'd2, 1'b0, 1'b1};
        vecs[9]  = '{2'd3, 1'b0, 1'b0};
        // stream after backpressure release
        vecs[10] = '{2'd3, 1'b0, 1'b0};
        vecs[11] = '{2'd0, 1'b0, 1'b1};
        vecs[12] = '{2'd1, 1'b1, 1'b1};

        rst = 1'b1;
        cfg_we1 = 1'b0; cfg_addr1 = 2'd0; cfg_data1 = 1'b0; cfg_en1 = 1'b0; miss_clr1 = 1'b0;
        cfg_we2 = 1'b0; cfg_addr2 = 2'd0; cfg_data2 = 1'b0; cfg_en2 = 1'b0; miss_clr2 = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_code = 2'd0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_code = 2'd0; bus2.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid",  32'(bus1.out_valid), 32'd0);
        chk("rst_data",   32'(bus1.out_data),  32'd0);
        chk("rst_hit",    32'(bus1.out_hit),   32'd0);
        chk("rst_cnt",    32'(miss_cnt1),      32'd0);
        chk("rst_sticky", 32'(miss_sticky1),   32'd0);
        chk("rst_ready",  32'(bus1.in_ready),  32'd1);

        // saturation on the 2-bit counter, then clear with a simultaneous miss
        for (int i = 1; i <= 5; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_code  = 2'(i);
            step();
            chk("sat_cnt", 32'(miss_cnt2), (i > 3) ? 32'd3 : 32'(i));
        end
        miss_clr2 = 1'b1;
        step();
        miss_clr2 = 1'b0;
        bus2.in_valid = 1'b0;
        chk("clr_miss_cnt",    32'(miss_cnt2),    32'd1);
        chk("clr_miss_sticky", 32'(miss_sticky2), 32'd1);

        run_vecs(0, 3, "empty_tbl");
        bus1.in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(bus1.out_valid), 32'd0);
        chk("sticky_set",  32'(miss_sticky1),   32'd1);

        miss_clr1 = 1'b1;
        step();
        miss_clr1 = 1'b0;
        exp_cnt = 0;
        chk("clr_cnt",    32'(miss_cnt1),    32'd0);
        chk("clr_sticky", 32'(miss_sticky1), 32'd0);

        // program entries 0 and 2; entry 1 is written later alongside a lookup
        cfg_we1 = 1'b1; cfg_en1 = 1'b1; cfg_data1 = 1'b0;
        cfg_addr1 = 2'd0;
        step();
        cfg_addr1 = 2'd2;
        step();

        // write entry 1 while accepting code 1: lookup sees the old (disabled) entry
        cfg_addr1 = 2'd1; cfg_data1 = 1'b1;
        bus1.in_valid = 1'b1; bus1.in_code = 2'd1;
        step();
        cfg_we1 = 1'b0;
        exp_cnt++;
        chk("wr_rd_data", 32'(bus1.out_data), 32'd0);
        chk("wr_rd_hit",  32'(bus1.out_hit),  32'd0);
        chk("wr_rd_cnt",  32'(miss_cnt1),     32'(exp_cnt));

        run_vecs(4, 9, "prog_tbl");

        // backpressure: hold a FULL result while a different code waits
        bus1.in_valid = 1'b0;
        step();
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_code = 2'd1;
        step();
        chk("bp_load_data", 32'(bus1.out_data), 32'd1);
        bus1.in_code = 2'd3;
        #1;
        chk("bp_in_ready", 32'(bus1.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", 32'(bus1.out_valid), 32'd1);
            chk("bp_data",  32'(bus1.out_data),  32'd1);
            chk("bp_hit",   32'(bus1.out_hit),   32'd1);
            chk("bp_cnt",   32'(miss_cnt1),      32'(exp_cnt));
        end
        bus1.out_ready = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus1.in_ready), 32'd1);
        run_vecs(10, 12, "release");
        bus1.in_valid = 1'b0;
        step();
        chk("release_drain", 32'(bus1.out_valid), 32'd0);

        // reset while FULL with a pending cfg write to entry 3
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_code = 2'd1;
        step();
        chk("pre_rst_full", 32'(bus1.out_valid), 32'd1);
        rst = 1'b1;
        cfg_we1 = 1'b1; cfg_addr1 = 2'd3; cfg_data1 = 1'b1; cfg_en1 = 1'b1;
        step();
        rst = 1'b0;
        cfg_we1 = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        exp_cnt = 0;
        chk("mid_rst_valid",  32'(bus1.out_valid), 32'd0);
        chk("mid_rst_cnt",    32'(miss_cnt1),      32'd0);
        chk("mid_rst_sticky", 32'(miss_sticky1),   32'd0);
        chk("mid_rst_data",   32'(bus1.out_data),  32'd0);
        run_vecs(0, 3, "post_rst");
        bus1.in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
